// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the two-port memory arbiter.
// State encoding, requester IDs and default word/address widths.
package mem_arbiter_pkg;

    localparam int unsigned DefBits = 32;
    localparam int unsigned DefAddr = 9;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StWait  = 2'd2,
        StResp  = 2'd3
    } state_e;

    typedef enum logic {
        PortIf = 1'b0,
        PortD  = 1'b1
    } port_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch port, data port and memory-side signals of the arbiter.
// slave is the arbiter's view; master is the requester/memory side.
interface mem_arbiter_if
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned BITS = DefBits,
    parameter int unsigned ADDR = DefAddr
);

    logic            ifReq;
    logic [ADDR-1:0] ifAddr;
    logic [BITS-1:0] ifRdata;
    logic            ifAck;

    logic            dReq;
    logic            dWrite;
    logic [ADDR-1:0] dAddr;
    logic [BITS-1:0] dWdata;
    logic [BITS-1:0] dRdata;
    logic            dAck;

    logic            ramRead;
    logic            ramWrite;
    logic [ADDR-1:0] ramAddress;
    logic [BITS-1:0] ramDataIn;
    logic [BITS-1:0] ramDataOut;

    modport slave (
        input  ifReq, ifAddr,
        output ifRdata, ifAck,
        input  dReq, dWrite, dAddr, dWdata,
        output dRdata, dAck,
        output ramRead, ramWrite, ramAddress, ramDataIn,
        input  ramDataOut
    );

    modport master (
        output ifReq, ifAddr,
        input  ifRdata, ifAck,
        output dReq, dWrite, dAddr, dWdata,
        input  dRdata, dAck,
        input  ramRead, ramWrite, ramAddress, ramDataIn,
        output ramDataOut
    );

endinterface

// File: rtl/rr_pick2.sv
// Combinational two-request round-robin pick.
// On a tie the port that did not win last time is chosen.
module rr_pick2
    import mem_arbiter_pkg::*;
(
    input  logic  req0,
    input  logic  req1,
    input  port_e last_grant,
    output port_e grant,
    output logic  valid
);

    always_comb begin
        valid = req0 | req1;
        grant = PortIf;
        if (req0 && req1) begin
            grant = (last_grant == PortIf) ? PortD : PortIf;
        end else if (req1) begin
            grant = PortD;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates an instruction-fetch port and a load/store port onto one
// single-ported memory with registered reads; all outputs are registered.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned BITS = DefBits,
    parameter int unsigned ADDR = DefAddr
) (
    input  logic          clk,
    input  logic          clr,
    mem_arbiter_if.slave  bus,
    output logic          busy
);

    state_e          state_q, state_d;
    port_e           winner_q, winner_d;
    port_e           last_grant_q, last_grant_d;
    logic            write_q, write_d;

    logic            ram_read_q, ram_read_d;
    logic            ram_write_q, ram_write_d;
    logic [ADDR-1:0] ram_addr_q, ram_addr_d;
    logic [BITS-1:0] ram_din_q, ram_din_d;
    logic            if_ack_q, if_ack_d;
    logic            d_ack_q, d_ack_d;
    logic [BITS-1:0] if_rdata_q, if_rdata_d;
    logic [BITS-1:0] d_rdata_q, d_rdata_d;
    logic            busy_q, busy_d;

    port_e           pick_grant;
    logic            pick_valid;

    rr_pick2 u_pick (
        .req0       (bus.ifReq),
        .req1       (bus.dReq),
        .last_grant (last_grant_q),
        .grant      (pick_grant),
        .valid      (pick_valid)
    );

    // Output registers are loaded with the values of the state being entered,
    // so the memory strobes and acks line up with ISSUE and RESP respectively.
    always_comb begin
        state_d      = state_q;
        winner_d     = winner_q;
        last_grant_d = last_grant_q;
        write_d      = write_q;
        ram_read_d   = 1'b0;
        ram_write_d  = 1'b0;
        ram_addr_d   = ram_addr_q;
        ram_din_d    = ram_din_q;
        if_ack_d     = 1'b0;
        d_ack_d      = 1'b0;
        if_rdata_d   = if_rdata_q;
        d_rdata_d    = d_rdata_q;

        unique case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    winner_d     = pick_grant;
                    last_grant_d = pick_grant;
                    state_d      = StIssue;
                    if (pick_grant == PortIf) begin
                        ram_addr_d = bus.ifAddr;
                        write_d    = 1'b0;
                    end else begin
                        ram_addr_d = bus.dAddr;
                        write_d    = bus.dWrite;
                    end
                    ram_read_d  = ~write_d;
                    ram_write_d = write_d;
                    if (write_d) begin
                        ram_din_d = bus.dWdata;
                    end
                end
            end
            StIssue: begin
                if (write_q) begin
                    state_d = StResp;
                    if (winner_q == PortIf) begin
                        if_ack_d = 1'b1;
                    end else begin
                        d_ack_d = 1'b1;
                    end
                end else begin
                    state_d = StWait;
                end
            end
            StWait: begin
                state_d = StResp;
                if (winner_q == PortIf) begin
                    if_rdata_d = bus.ramDataOut;
                    if_ack_d   = 1'b1;
                end else begin
                    d_rdata_d = bus.ramDataOut;
                    d_ack_d   = 1'b1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q      <= StIdle;
            winner_q     <= PortIf;
            last_grant_q <= PortD;
            write_q      <= 1'b0;
            ram_read_q   <= 1'b0;
            ram_write_q  <= 1'b0;
            ram_addr_q   <= '0;
            ram_din_q    <= '0;
            if_ack_q     <= 1'b0;
            d_ack_q      <= 1'b0;
            if_rdata_q   <= '0;
            d_rdata_q    <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            winner_q     <= winner_d;
            last_grant_q <= last_grant_d;
            write_q      <= write_d;
            ram_read_q   <= ram_read_d;
            ram_write_q  <= ram_write_d;
            ram_addr_q   <= ram_addr_d;
            ram_din_q    <= ram_din_d;
            if_ack_q     <= if_ack_d;
            d_ack_q      <= d_ack_d;
            if_rdata_q   <= if_rdata_d;
            d_rdata_q    <= d_rdata_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.ramRead    = ram_read_q;
    assign bus.ramWrite   = ram_write_q;
    assign bus.ramAddress = ram_addr_q;
    assign bus.ramDataIn  = ram_din_q;
    assign bus.ifAck      = if_ack_q;
    assign bus.dAck       = d_ack_q;
    assign bus.ifRdata    = if_rdata_q;
    assign bus.dRdata     = d_rdata_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a 512x32 registered-read RAM model.
// Stimulus pushes expected acks; a negedge monitor pops and compares them.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int unsigned BITS = 32;
    localparam int unsigned ADDR = 9;

    logic clk = 1'b0;
    logic clr = 1'b1;
    logic busy;

    always #5 clk = ~clk;

    mem_arbiter_if #(.BITS(BITS), .ADDR(ADDR)) bus ();

    mem_arbiter #(.BITS(BITS), .ADDR(ADDR)) dut (
        .clk  (clk),
        .clr  (clr),
        .bus  (bus),
        .busy (busy)
    );

    logic [BITS-1:0] ram [512];

    initial begin
        for (int i = 0; i < 512; i++) begin
            ram[i] <= 32'hA500_0000 | 32'(i);
        end
        ram[4] <= 32'h0000_F7F7;
    end

    always @(posedge clk) begin
        if (bus.ramWrite) ram[bus.ramAddress] <= bus.ramDataIn;
        if (bus.ramRead) bus.ramDataOut <= ram[bus.ramAddress];
    end

    typedef struct packed {
        port_e       port;
        logic        wr;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   pass_cnt = 0;
    int   total_cnt = 0;
    logic both_seen = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s: actual=%h required=%h", name, act, req);
    endtask

    task automatic push_exp(input port_e p, input logic wr, input logic [31:0] d);
        exp_t e;
        e.port = p;
        e.wr   = wr;
        e.data = d;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (bus.ramRead && bus.ramWrite) both_seen = 1'b1;
        if (bus.ifAck || bus.dAck) begin
            if (exp_q.size() == 0) begin
                check("unexpected_ack", {30'd0, bus.ifAck, bus.dAck}, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("ack_port", {30'd0, bus.ifAck, bus.dAck},
                      (mon_e.port == PortIf) ? 32'd2 : 32'd1);
                if (!mon_e.wr) begin
                    check("rdata", (mon_e.port == PortIf) ? bus.ifRdata : bus.dRdata,
                          mon_e.data);
                end
            end
        end
    end

    // Issue one request from idle, check its ack latency, then return to idle.
    task automatic single(input port_e p, input logic wr, input logic [8:0] a,
                          input logic [31:0] wd, input logic [31:0] ed, input int lat,
                          input string name);
        logic got;
        push_exp(p, wr, ed);
        if (p == PortIf) begin
            bus.ifReq  = 1'b1;
            bus.ifAddr = a;
        end else begin
            bus.dReq   = 1'b1;
            bus.dWrite = wr;
            bus.dAddr  = a;
            bus.dWdata = wd;
        end
        got = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if ((p == PortIf && bus.ifAck) || (p == PortD && bus.dAck)) begin
                check({name, "_latency"}, 32'(k), 32'(lat));
                got = 1'b1;
                break;
            end
        end
        if (!got) check({name, "_timeout"}, 32'd0, 32'd1);
        bus.ifReq = 1'b0;
        bus.dReq  = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int if_at, d_at, n, last_k;
        logic got;
        bus.ifReq  = 1'b0;
        bus.ifAddr = '0;
        bus.dReq   = 1'b0;
        bus.dWrite = 1'b0;
        bus.dAddr  = '0;
        bus.dWdata = '0;
        clr        = 1'b1;
        repeat (2) @(negedge clk);

        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_strobes", {28'd0, bus.ramRead, bus.ramWrite, bus.ifAck, bus.dAck}, 32'd0);
        check("rst_ramaddr", {23'd0, bus.ramAddress}, 32'd0);
        check("rst_ramdin", bus.ramDataIn, 32'd0);
        check("rst_ifrdata", bus.ifRdata, 32'd0);
        check("rst_drdata", bus.dRdata, 32'd0);
        clr = 1'b0;
        @(negedge clk);

        // Single fetch, then data write and read-back
        single(PortIf, 1'b0, 9'd4, 32'd0, 32'h0000_F7F7, 3, "fetch4");
        single(PortD, 1'b1, 9'd90, 32'h55, 32'd0, 2, "dwrite90");
        single(PortD, 1'b0, 9'd90, 32'd0, 32'h55, 3, "dread90");

        // Simultaneous requests right after reset: fetch wins the first tie
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        push_exp(PortIf, 1'b0, 32'h0000_F7F7);
        push_exp(PortD, 1'b0, 32'hA500_000A);
        bus.ifReq  = 1'b1;
        bus.ifAddr = 9'd4;
        bus.dReq   = 1'b1;
        bus.dWrite = 1'b0;
        bus.dAddr  = 9'd10;
        if_at = 0;
        d_at  = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (bus.ifAck && if_at == 0) begin
                if_at     = k;
                bus.ifReq = 1'b0;
            end
            if (bus.dAck && d_at == 0) begin
                d_at     = k;
                bus.dReq = 1'b0;
                break;
            end
        end
        bus.ifReq = 1'b0;
        bus.dReq  = 1'b0;
        check("tie_if_cycle", 32'(if_at), 32'd3);
        check("tie_d_cycle", 32'(d_at), 32'd7);
        @(negedge clk);

        // Both held for six transactions: strict alternation IF, D, ...
        for (int i = 0; i < 3; i++) begin
            push_exp(PortIf, 1'b0, 32'h0000_F7F7);
            push_exp(PortD, 1'b0, 32'hA500_0014);
        end
        bus.ifReq  = 1'b1;
        bus.ifAddr = 9'd4;
        bus.dReq   = 1'b1;
        bus.dWrite = 1'b0;
        bus.dAddr  = 9'd20;
        n      = 0;
        last_k = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (bus.ifAck || bus.dAck) begin
                n++;
                last_k = k;
            end
            if (n == 6) break;
        end
        bus.ifReq = 1'b0;
        bus.dReq  = 1'b0;
        check("alt_count", 32'(n), 32'd6);
        check("alt_last_cycle", 32'(last_k), 32'd23);
        @(negedge clk);

        // clr during WAIT of a fetch aborts it without an ack
        bus.ifReq  = 1'b1;
        bus.ifAddr = 9'd7;
        repeat (2) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_ifack", {31'd0, bus.ifAck}, 32'd0);
        check("abort_ifrdata", bus.ifRdata, 32'd0);
        bus.ifReq = 1'b0;
        clr       = 1'b0;
        single(PortIf, 1'b0, 9'd7, 32'd0, 32'hA500_0007, 3, "fetch_after_clr");

        // Operand changes after the grant are ignored
        push_exp(PortD, 1'b0, 32'hA500_000A);
        bus.dReq   = 1'b1;
        bus.dWrite = 1'b0;
        bus.dAddr  = 9'd10;
        @(negedge clk);
        check("issue_ramaddr", {23'd0, bus.ramAddress}, 32'd10);
        check("issue_ramread", {30'd0, bus.ramRead, bus.ramWrite}, 32'd2);
        bus.dAddr  = 9'd20;
        bus.dWrite = 1'b1;
        bus.dWdata = 32'hDEAD_BEEF;
        got = 1'b0;
        for (int k = 2; k <= 12; k++) begin
            @(negedge clk);
            if (bus.dAck) begin
                check("addr_change_latency", 32'(k), 32'd3);
                got = 1'b1;
                break;
            end
        end
        if (!got) check("addr_change_timeout", 32'd0, 32'd1);
        bus.dReq   = 1'b0;
        bus.dWrite = 1'b0;
        @(negedge clk);

        // dRdata holds across an unrelated fetch
        single(PortIf, 1'b0, 9'd4, 32'd0, 32'h0000_F7F7, 3, "fetch_hold");
        check("drdata_hold", bus.dRdata, 32'hA500_000A);
        check("ram20_untouched", ram[20], 32'hA500_0014);

        check("rw_never_both", {31'd0, both_seen}, 32'd0);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: actual=running required=finished");
        $fatal(1);
    end

endmodule
